vp_bus_adapter: RTL and testbench
=================================

// Module: vp_bus_adapter
// PURPOSE
//  Bus-slave front end for the VP1-014 timer: decodes a 16-byte register window,
//  turns a four-phase req/ack host cycle into single-cycle ce/regwr/regrd strobes,
//  captures the timer's registered read data and returns it to the host.
//  Sits directly upstream of the timer and drives its ce/regwr/regrd/addr/data_i;
//  the timer's data_o is fed back into dev_rdata.
// PARAMETERS
//  BASE_ADDR  16'o177700  window base; hit when bus_addr[15:4]==BASE_ADDR[15:4]
// PORTS
//  clk        in   1   system clock
//  reset_n    in   1   asynchronous, active-low reset
//  bus_req    in   1   host cycle request, held until bus_ack seen
//  bus_we     in   1   1=write, 0=read; sampled with bus_req
//  bus_byte   in   1   byte write (bus_addr[0] selects lane: 0=low, 1=high)
//  bus_addr   in   16  byte address
//  bus_wdata  in   16  write data
//  bus_rdata  out  16  read data, valid while bus_ack=1
//  bus_ack    out  1   reply; held until bus_req drops
//  dev_ce     out  1   one-cycle strobe qualifier to timer
//  dev_regwr  out  1   write strobe (with dev_ce)
//  dev_regrd  out  1   read strobe (with dev_ce)
//  dev_addr   out  4   register offset = {bus_addr[3:1],1'b0}
//  dev_wdata  out  16  write data to timer
//  dev_rdata  in   16  timer data_o, valid 1 cycle after dev_regrd strobe
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE; async assert aborts any cycle, no ack issued.
//  States: IDLE, RD_STB, RD_CAP, WR_STB, ACK.
//  IDLE: on bus_req=1 and window hit, latch addr/we/byte/wdata; go
//   RD_STB if read (or byte write with macro), else WR_STB. Miss: stay IDLE,
//   no strobes, no ack (host bus timeout handles it).
//  RD_STB: dev_ce=dev_regrd=1 for exactly 1 cycle -> RD_CAP.
//  RD_CAP: bus_rdata<=dev_rdata; -> WR_STB if RMW pending, else ACK.
//  WR_STB: dev_ce=dev_regwr=1, dev_wdata=latched/merged word, 1 cycle -> ACK.
//  ACK: bus_ack=1 while bus_req=1; bus_req=0 -> bus_ack=0, IDLE next cycle.
//  Latency (req seen at cycle 0): word write ack at 2, read ack at 3,
//   RMW byte write ack at 4. Min 1 IDLE cycle between transactions.
//  Strobes never overlap; dev_regwr and dev_regrd never both 1.
//  bus_req dropped before ACK: started internal access completes (strobes not
//   suppressed), ACK state sees req=0 and returns IDLE without asserting ack.
//  bus_req changes of addr/data after latch are ignored for current cycle.
//  dev_ce=0 in all states except RD_STB/WR_STB. bus_rdata holds last capture.
// CONFIGURATION
//  VP_BUSADP_BYTE_RMW_EN defined: byte write = read-modify-write; RD_STB/RD_CAP
//   read the register, merge selected lane (addr[0]=1 -> [15:8]<=wdata[15:8],
//   else [7:0]<=wdata[7:0]), then WR_STB writes the merged word.
//  Undefined: bus_byte ignored; byte write issued as plain word write of
//   bus_wdata (whole register overwritten), ack at cycle 2.
// TESTING
//  Write 0o177706 data 16'h1234 -> one dev_regwr pulse, dev_addr=4'o06,
//   dev_wdata=16'h1234, bus_ack rises cycle 2, drops 1 cycle after bus_req falls.
//  Read 0o177710, dev_rdata model = 16'hBEEF 1 cycle after strobe ->
//   bus_rdata=16'hBEEF with bus_ack at cycle 3, exactly one dev_regrd pulse.
//  Read 0o177600 (miss) -> no dev_ce for 10 cycles, bus_ack stays 0.
//  Macro on: reg=16'h1234, byte write 16'hAB00 to 0o177707 -> regrd then
//   regwr of 16'hAB34, ack cycle 4; macro off: word write 16'hAB00, ack cycle 2.
//  bus_req dropped at cycle 1 of a read -> strobe completes, bus_ack never 1,
//   FSM IDLE; next read accepted normally.
//  reset_n low during WR_STB -> dev_* and bus_ack 0 immediately, IDLE after release.

Source files
------------

// File: rtl/vp_bus_adapter_if.sv
// Host-side bus bundle for the VP1-014 timer bus adapter.
// The host drives the request/address/data lines (master); the adapter
// returns read data and the four-phase acknowledge (slave).
`timescale 1ns/1ps

interface vp_bus_adapter_if;
   logic        bus_req;
   logic        bus_we;
   logic        bus_byte;
   logic [15:0] bus_addr;
   logic [15:0] bus_wdata;
   logic [15:0] bus_rdata;
   logic        bus_ack;

   modport master (
      output bus_req,
      output bus_we,
      output bus_byte,
      output bus_addr,
      output bus_wdata,
      input  bus_rdata,
      input  bus_ack
   );

   modport slave (
      input  bus_req,
      input  bus_we,
      input  bus_byte,
      input  bus_addr,
      input  bus_wdata,
      output bus_rdata,
      output bus_ack
   );
endinterface

// File: rtl/vp_bus_adapter.sv
// Bus-slave front end for the VP1-014 timer.
// Decodes a 16-byte register window at BASE_ADDR, converts a four-phase
// req/ack host cycle into single-cycle ce/regwr/regrd strobes, captures the
// timer's registered read data and returns it on bus_rdata.
// Optional feature macro: VP_BUSADP_BYTE_RMW_EN -- when defined, byte writes
// are performed as read-modify-write of the addressed register; otherwise
// bus_byte is ignored and every write overwrites the whole register.
`timescale 1ns/1ps

module vp_bus_adapter #(
   parameter logic [15:0] BASE_ADDR = 16'o177700
) (
   input  logic               clk,
   input  logic               reset_n,
   vp_bus_adapter_if.slave    bus,
   output logic               dev_ce,
   output logic               dev_regwr,
   output logic               dev_regrd,
   output logic [3:0]         dev_addr,
   output logic [15:0]        dev_wdata,
   input  logic [15:0]        dev_rdata
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD_STB = 3'd1,
      ST_RD_CAP = 3'd2,
      ST_WR_STB = 3'd3,
      ST_ACK    = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  reg_idx_q, reg_idx_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic        ack_q, ack_d;
   logic        win_hit;

`ifdef VP_BUSADP_BYTE_RMW_EN
   logic        rmw_q, rmw_d;
   logic        hi_lane_q, hi_lane_d;

   // Replace one byte lane of the current register value with host data.
   function automatic logic [15:0] merge_lane(input logic [15:0] cur,
                                              input logic [15:0] wr,
                                              input logic        hi);
      logic [15:0] res;
      if (hi) begin
         res = {wr[15:8], cur[7:0]};
      end else begin
         res = {cur[15:8], wr[7:0]};
      end
      return res;
   endfunction
`endif

   assign win_hit = (bus.bus_addr[15:4] == BASE_ADDR[15:4]);

   // Next-state and latch logic for one host cycle; address/data are
   // frozen at acceptance so later bus changes cannot disturb the access.
   always_comb begin
      state_d   = state_q;
      reg_idx_d = reg_idx_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      ack_d     = 1'b0;
`ifdef VP_BUSADP_BYTE_RMW_EN
      rmw_d     = rmw_q;
      hi_lane_d = hi_lane_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // A miss is silently ignored; the host's own timeout recovers.
            if (bus.bus_req && win_hit) begin
               reg_idx_d = bus.bus_addr[3:1];
               wdata_d   = bus.bus_wdata;
               state_d   = bus.bus_we ? ST_WR_STB : ST_RD_STB;
`ifdef VP_BUSADP_BYTE_RMW_EN
               hi_lane_d = bus.bus_addr[0];
               rmw_d     = bus.bus_we & bus.bus_byte;
               if (bus.bus_we && bus.bus_byte) begin
                  state_d = ST_RD_STB;
               end
`endif
            end
         end
         ST_RD_STB: begin
            state_d = ST_RD_CAP;
         end
         ST_RD_CAP: begin
            // Timer data is valid the cycle after the read strobe.
            rdata_d = dev_rdata;
            state_d = ST_ACK;
            ack_d   = bus.bus_req;
`ifdef VP_BUSADP_BYTE_RMW_EN
            if (rmw_q) begin
               wdata_d = merge_lane(dev_rdata, wdata_q, hi_lane_q);
               rmw_d   = 1'b0;
               state_d = ST_WR_STB;
               ack_d   = 1'b0;
            end
`endif
         end
         ST_WR_STB: begin
            state_d = ST_ACK;
            ack_d   = bus.bus_req;
         end
         ST_ACK: begin
            // An abandoned cycle (req already low) returns without acking.
            if (bus.bus_req) begin
               ack_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Strobes are decoded straight from the state register so that an
   // asynchronous reset removes them immediately.
   always_comb begin
      dev_ce    = 1'b0;
      dev_regwr = 1'b0;
      dev_regrd = 1'b0;
      case (state_q)
         ST_RD_STB: begin
            dev_ce    = 1'b1;
            dev_regrd = 1'b1;
         end
         ST_WR_STB: begin
            dev_ce    = 1'b1;
            dev_regwr = 1'b1;
         end
         default: begin
            dev_ce    = 1'b0;
         end
      endcase
   end

   assign dev_addr      = {reg_idx_q, 1'b0};
   assign dev_wdata     = wdata_q;
   assign bus.bus_rdata = rdata_q;
   assign bus.bus_ack   = ack_q;

   // State and latched-transaction registers; reset clears every output.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         reg_idx_q <= 3'd0;
         wdata_q   <= 16'h0000;
         rdata_q   <= 16'h0000;
         ack_q     <= 1'b0;
`ifdef VP_BUSADP_BYTE_RMW_EN
         rmw_q     <= 1'b0;
         hi_lane_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         reg_idx_q <= reg_idx_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         ack_q     <= ack_d;
`ifdef VP_BUSADP_BYTE_RMW_EN
         rmw_q     <= rmw_d;
         hi_lane_q <= hi_lane_d;
`endif
      end
   end

endmodule

// File: tb/tb_vp_bus_adapter.sv
// Testbench for vp_bus_adapter: directed host cycles against a small timer
// register model, a cycle-indexed expectation table and a per-cycle compare.
`timescale 1ns/1ps

module tb_vp_bus_adapter;
   localparam int NW = 1024;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   vp_bus_adapter_if bus ();

   logic        dev_ce, dev_regwr, dev_regrd;
   logic [3:0]  dev_addr;
   logic [15:0] dev_wdata;
   logic [15:0] dev_rdata = 16'h0000;

   vp_bus_adapter #(.BASE_ADDR(16'o177700)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus),
      .dev_ce    (dev_ce),
      .dev_regwr (dev_regwr),
      .dev_regrd (dev_regrd),
      .dev_addr  (dev_addr),
      .dev_wdata (dev_wdata),
      .dev_rdata (dev_rdata)
   );

   // Timer register file: write on strobe, read data registered one cycle later.
   logic [15:0] treg [8] = '{default: 16'h0000};
   always @(posedge clk) begin
      if (dev_ce && dev_regwr) treg[dev_addr[3:1]] <= dev_wdata;
      if (dev_ce && dev_regrd) dev_rdata <= treg[dev_addr[3:1]];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected behaviour, indexed by cycle number.
   bit        exp_wr  [NW];
   bit        exp_rd  [NW];
   bit        exp_ack [NW];
   bit [3:0]  exp_adr [NW];
   bit [15:0] exp_wd  [NW];
   bit [15:0] exp_rdv [NW];
   bit [15:0] exp_reg [8];
   bit [15:0] last_cap = 16'h0000;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;
   int n_ce = 0, n_wr = 0, n_rd = 0, n_ack = 0;
   int ack_rise_w = -1;
   logic ack_prev = 1'b0;

   task automatic chk1(input string nm, input logic act, input logic req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %b, required %b", nm, cyc, act, req);
      end
   endtask

   task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, required %h", nm, cyc, act, req);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, required %0d", nm, cyc, act, req);
      end
   endtask

   // Per-cycle compare of all DUT outputs against the expectation table.
   always @(negedge clk) begin
      if (chk_en && cyc < NW) begin
         chk1("ce", dev_ce, exp_wr[cyc] | exp_rd[cyc]);
         chk1("regwr", dev_regwr, exp_wr[cyc]);
         chk1("regrd", dev_regrd, exp_rd[cyc]);
         chk1("ack", bus.bus_ack, exp_ack[cyc]);
         if (exp_wr[cyc] || exp_rd[cyc])
            chk16("dev_addr", {12'h000, dev_addr}, {12'h000, exp_adr[cyc]});
         if (exp_wr[cyc])
            chk16("dev_wdata", dev_wdata, exp_wd[cyc]);
         if (exp_ack[cyc])
            chk16("bus_rdata", bus.bus_rdata, exp_rdv[cyc]);
      end
      if (reset_n === 1'b1) begin
         if (dev_ce) n_ce++;
         if (dev_regwr) n_wr++;
         if (dev_regrd) n_rd++;
         if (bus.bus_ack) n_ack++;
         if (bus.bus_ack && !ack_prev) ack_rise_w = cyc;
         ack_prev = bus.bus_ack;
      end
   end

   // Fill the expectation table for a cycle accepted at c0 with req last
   // high in cycle r-1 (dropped during cycle r); returns ack latency.
   task automatic plan(input int c0, input int r, input bit wr, input bit byt,
                       input logic [15:0] addr, input logic [15:0] data, output int a);
      int i;
      bit [15:0] rdv;
      bit [15:0] merged;
      i = int'(addr[3:1]);
      rdv = last_cap;
      merged = data;
      if (!wr) begin
         a = 3;
         exp_rd[c0+1] = 1'b1;
         exp_adr[c0+1] = {addr[3:1], 1'b0};
         last_cap = exp_reg[i];
         rdv = last_cap;
      end
`ifdef VP_BUSADP_BYTE_RMW_EN
      else if (byt) begin
         a = 4;
         exp_rd[c0+1] = 1'b1;
         exp_adr[c0+1] = {addr[3:1], 1'b0};
         merged = addr[0] ? {data[15:8], exp_reg[i][7:0]} : {exp_reg[i][15:8], data[7:0]};
         exp_wr[c0+3] = 1'b1;
         exp_adr[c0+3] = {addr[3:1], 1'b0};
         exp_wd[c0+3] = merged;
         last_cap = exp_reg[i];
         rdv = last_cap;
         exp_reg[i] = merged;
      end
`endif
      else begin
         a = 2;
         if (byt) merged = data;
         exp_wr[c0+1] = 1'b1;
         exp_adr[c0+1] = {addr[3:1], 1'b0};
         exp_wd[c0+1] = merged;
         exp_reg[i] = merged;
      end
      for (int w = c0 + a; w <= r; w++) begin
         exp_ack[w] = 1'b1;
         exp_rdv[w] = rdv;
      end
   endtask

   // One host cycle: req held for 'hold' cycles, addr/data scrambled after
   // acceptance; returns once the adapter is idle again.
   task automatic do_txn(input bit wr, input bit byt, input logic [15:0] addr,
                         input logic [15:0] data, input int hold, output int c0);
      int a;
      int end_w;
      bit hit;
      @(negedge clk);
      c0 = cyc;
      hit = ((addr & 16'hFFF0) == 16'o177700);
      a = 0;
      if (hit) plan(c0, c0 + hold, wr, byt, addr, data, a);
      bus.bus_req = 1'b1;
      bus.bus_we = wr;
      bus.bus_byte = byt;
      bus.bus_addr = addr;
      bus.bus_wdata = data;
      for (int k = 1; k <= hold; k++) begin
         @(negedge clk);
         if (k == 1) begin
            bus.bus_addr = 16'h0000;
            bus.bus_wdata = 16'hFFFF;
         end
      end
      bus.bus_req = 1'b0;
      end_w = (!hit || hold >= a) ? c0 + hold + 1 : c0 + a + 1;
      while (cyc < end_w) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, s_wr, s_rd, s_ce, s_ack;
      reset_n = 1'b0;
      bus.bus_req = 1'b0;
      bus.bus_we = 1'b0;
      bus.bus_byte = 1'b0;
      bus.bus_addr = 16'h0000;
      bus.bus_wdata = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_ce", dev_ce, 1'b0);
      chk1("rst_regwr", dev_regwr, 1'b0);
      chk1("rst_regrd", dev_regrd, 1'b0);
      chk1("rst_ack", bus.bus_ack, 1'b0);
      chk16("rst_rdata", bus.bus_rdata, 16'h0000);
      chk16("rst_addr", {12'h000, dev_addr}, 16'h0000);
      chk16("rst_wdata", dev_wdata, 16'h0000);
      @(negedge clk);
      reset_n = 1'b1;
      chk_en = 1'b1;

      // Word write 0o177706 <- 1234
      s_wr = n_wr; s_ack = n_ack;
      do_txn(1'b1, 1'b0, 16'o177706, 16'h1234, 3, c0);
      chk_int("wr_pulses", n_wr - s_wr, 1);
      chk_int("wr_ack_latency", ack_rise_w - c0, 2);
      chk_int("wr_ack_cycles", n_ack - s_ack, 2);
      chk16("wr_timer_reg", treg[3], 16'h1234);

      // Load BEEF at 0o177710, then read it back
      do_txn(1'b1, 1'b0, 16'o177710, 16'hBEEF, 2, c0);
      s_rd = n_rd;
      do_txn(1'b0, 1'b0, 16'o177710, 16'h0000, 4, c0);
      chk_int("rd_pulses", n_rd - s_rd, 1);
      chk_int("rd_ack_latency", ack_rise_w - c0, 3);
      chk16("rd_data", bus.bus_rdata, 16'hBEEF);

      // Window miss
      s_ce = n_ce; s_ack = n_ack;
      do_txn(1'b0, 1'b0, 16'o177600, 16'h0000, 10, c0);
      chk_int("miss_ce", n_ce - s_ce, 0);
      chk_int("miss_ack", n_ack - s_ack, 0);

      // Byte write high lane
      s_wr = n_wr; s_rd = n_rd;
      do_txn(1'b1, 1'b1, 16'o177707, 16'hAB00, 5, c0);
      chk_int("bw_wr_pulses", n_wr - s_wr, 1);
`ifdef VP_BUSADP_BYTE_RMW_EN
      chk_int("bw_ack_latency", ack_rise_w - c0, 4);
      chk_int("bw_rd_pulses", n_rd - s_rd, 1);
      chk16("bw_timer_reg", treg[3], 16'hAB34);
`else
      chk_int("bw_ack_latency", ack_rise_w - c0, 2);
      chk_int("bw_rd_pulses", n_rd - s_rd, 0);
      chk16("bw_timer_reg", treg[3], 16'hAB00);
`endif

      // Read abandoned after one cycle, then a normal read
      s_rd = n_rd; s_ack = n_ack;
      do_txn(1'b0, 1'b0, 16'o177706, 16'h0000, 1, c0);
      chk_int("abort_rd_pulses", n_rd - s_rd, 1);
      chk_int("abort_ack", n_ack - s_ack, 0);
      do_txn(1'b0, 1'b0, 16'o177706, 16'h0000, 3, c0);
      chk_int("after_abort_latency", ack_rise_w - c0, 3);
`ifdef VP_BUSADP_BYTE_RMW_EN
      chk16("after_abort_data", bus.bus_rdata, 16'hAB34);
`else
      chk16("after_abort_data", bus.bus_rdata, 16'hAB00);
`endif

      // Byte write low lane, read back
      do_txn(1'b1, 1'b1, 16'o177706, 16'h55CD, 4, c0);
      do_txn(1'b0, 1'b0, 16'o177706, 16'h0000, 3, c0);
`ifdef VP_BUSADP_BYTE_RMW_EN
      chk16("low_lane_data", bus.bus_rdata, 16'hABCD);
`else
      chk16("low_lane_data", bus.bus_rdata, 16'h55CD);
`endif

      // Word write at odd address of the last register
      do_txn(1'b1, 1'b0, 16'o177717, 16'hA5A5, 2, c0);
      chk16("odd_addr_reg", treg[7], 16'hA5A5);

      // Reset during the write strobe
      chk_en = 1'b0;
      @(negedge clk);
      bus.bus_req = 1'b1;
      bus.bus_we = 1'b1;
      bus.bus_byte = 1'b0;
      bus.bus_addr = 16'o177702;
      bus.bus_wdata = 16'h7777;
      @(posedge clk);
      #2;
      chk1("pre_rst_strobe", dev_ce & dev_regwr, 1'b1);
      reset_n = 1'b0;
      #1;
      chk1("arst_ce", dev_ce, 1'b0);
      chk1("arst_regwr", dev_regwr, 1'b0);
      chk1("arst_regrd", dev_regrd, 1'b0);
      chk1("arst_ack", bus.bus_ack, 1'b0);
      chk16("arst_addr", {12'h000, dev_addr}, 16'h0000);
      chk16("arst_wdata", dev_wdata, 16'h0000);
      chk16("arst_rdata", bus.bus_rdata, 16'h0000);
      bus.bus_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      last_cap = 16'h0000;
      chk_en = 1'b1;
      chk16("arst_no_write", treg[1], 16'h0000);
      do_txn(1'b0, 1'b0, 16'o177710, 16'h0000, 3, c0);
      chk_int("post_rst_latency", ack_rise_w - c0, 3);
      chk16("post_rst_data", bus.bus_rdata, 16'hBEEF);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
